fw_interface_wb: RTL

FW_INTERFACE_WB -- requirements
Module: fw_interface_wb

---
 rtl/fw_interface_defs.sv | 16 +
 rtl/fw_interface_wb_if.sv | 14 +
 rtl/fw_string_serializer.sv | 59 +++++
 rtl/fw_interface_wb.sv | 78 +++++++
 4 files changed

// File: rtl/fw_interface_defs.sv
// fw_interface_defs: register map, string depth default and serializer encoding shared by the firmware interface
package fw_interface_defs;
  localparam int STR_DEPTH_DEF = 64;
  localparam logic [2:0] REG_REPORT  = 3'd0;
  localparam logic [2:0] REG_WARNING = 3'd1;
  localparam logic [2:0] REG_ERROR   = 3'd2;
  localparam logic [2:0] REG_STRING  = 3'd3;
  localparam logic [2:0] REG_INDEX   = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;
  typedef enum logic {SER_IDLE = 1'b0, SER_RUN = 1'b1} ser_state_t;
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] sel);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return v;
  endfunction
endpackage

// File: rtl/fw_interface_wb_if.sv
// fw_interface_wb_if: Wishbone classic slave bus bundle
interface fw_interface_wb_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [4:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  modport slave  (input wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, output wb_dat_o, wb_ack_o, wb_err_o);
  modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, input wb_dat_o, wb_ack_o, wb_err_o);
endinterface

// File: rtl/fw_string_serializer.sv
// fw_string_serializer: spills a latched word into string memory one byte lane per cycle
module fw_string_serializer
  import fw_interface_defs::*;
#(
  parameter int STR_DEPTH = STR_DEPTH_DEF,
  localparam int IW = $clog2(STR_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [31:0]   i_word,
  input  logic [3:0]    i_sel,
  input  logic          i_idx_we,
  input  logic [IW-1:0] i_idx,
  output logic [IW-1:0] o_index,
  output logic [7:0]    o_data,
  output logic          o_write_mem,
  output logic          o_busy
);
  ser_state_t r_state, w_next;
  logic [31:0] r_word;
  logic [3:0] r_sel;
  logic [1:0] r_lane;
  logic [IW-1:0] r_index, w_inc;
  logic [7:0] w_byte;
  logic w_idle, w_emit, w_term;
  assign w_idle = r_state == SER_IDLE;
  assign w_byte = r_word[{r_lane, 3'b000} +: 8];
  assign w_emit = !w_idle && r_sel[r_lane];
  assign w_term = w_emit && w_byte == 8'h00;
  assign w_inc = (r_index == IW'(STR_DEPTH - 1)) ? '0 : r_index + 1'b1;
  assign o_index = r_index;
  assign o_data = w_emit ? w_byte : 8'h00;
  assign o_write_mem = w_emit;
  assign o_busy = !w_idle;
  always_comb begin
    w_next = r_state;
    if (w_idle) w_next = i_start ? SER_RUN : SER_IDLE;
    else w_next = (w_term || r_lane == 2'd3) ? SER_IDLE : SER_RUN;
  end
  // a terminator byte rewinds the index so the next string starts at 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= SER_IDLE;
      r_word <= '0;
      r_sel <= '0;
      r_lane <= '0;
      r_index <= '0;
    end else begin
      r_state <= w_next;
      r_lane <= w_idle ? 2'd0 : r_lane + 2'd1;
      if (w_idle && i_start) begin
        r_word <= i_word;
        r_sel <= i_sel;
      end
      if (w_idle && i_idx_we) r_index <= i_idx;
      else if (w_emit) r_index <= w_term ? '0 : w_inc;
    end
endmodule

// File: rtl/fw_interface_wb.sv
// fw_interface_wb: Wishbone slave exposing firmware report/warning/error registers and a string byte port
module fw_interface_wb
  import fw_interface_defs::*;
#(
  parameter int STR_DEPTH = STR_DEPTH_DEF,
  localparam int IW = $clog2(STR_DEPTH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  fw_interface_wb_if.slave  wb,
  output logic              new_report,
  output logic              new_warning,
  output logic              new_error,
  output logic [31:0]       report_reg,
  output logic [31:0]       warning_reg,
  output logic [31:0]       error_reg,
  output logic [IW-1:0]     index,
  output logic [7:0]        data,
  output logic              write_mem
);
  logic r_ack, r_err;
  logic [31:0] r_dat, r_report, r_warning, r_error, w_rdata;
  logic [2:0] r_new, w_reg;
  logic [IW-1:0] w_index;
  logic w_req, w_bad, w_stall, w_go, w_wr, w_busy, w_unused;
  assign w_reg = wb.wb_adr_i[4:2];
  assign w_unused = ^wb.wb_adr_i[1:0];
  assign w_req = wb.wb_cyc_i && wb.wb_stb_i && !r_ack && !r_err;
  assign w_bad = w_reg > REG_STATUS || (w_reg == REG_STATUS && wb.wb_we_i);
  // string/index writes wait for the serializer so the index cannot move under it
  assign w_stall = wb.wb_we_i && (w_reg == REG_STRING || w_reg == REG_INDEX) && w_busy;
  assign w_go = w_req && !w_stall;
  assign w_wr = w_go && !w_bad && wb.wb_we_i;
  assign w_rdata = w_reg == REG_REPORT  ? r_report :
                   w_reg == REG_WARNING ? r_warning :
                   w_reg == REG_ERROR   ? r_error :
                   w_reg == REG_INDEX   ? {{(32-IW){1'b0}}, w_index} :
                   w_reg == REG_STATUS  ? {{(25-IW){1'b0}}, w_index, 7'b0, w_busy} : 32'h0;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
      r_new <= '0;
      r_report <= '0;
      r_warning <= '0;
      r_error <= '0;
    end else begin
      r_ack <= w_go && !w_bad;
      r_err <= w_go && w_bad;
      r_dat <= (w_go && !w_bad && !wb.wb_we_i) ? w_rdata : 32'h0;
      r_new <= {3{w_wr}} & {w_reg == REG_ERROR, w_reg == REG_WARNING, w_reg == REG_REPORT};
      if (w_wr && w_reg == REG_REPORT) r_report <= byte_merge(r_report, wb.wb_dat_i, wb.wb_sel_i);
      if (w_wr && w_reg == REG_WARNING) r_warning <= byte_merge(r_warning, wb.wb_dat_i, wb.wb_sel_i);
      if (w_wr && w_reg == REG_ERROR) r_error <= byte_merge(r_error, wb.wb_dat_i, wb.wb_sel_i);
    end
  fw_string_serializer #(.STR_DEPTH(STR_DEPTH)) u_ser (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .i_start(w_wr && w_reg == REG_STRING),
    .i_word(wb.wb_dat_i),
    .i_sel(wb.wb_sel_i),
    .i_idx_we(w_wr && w_reg == REG_INDEX && wb.wb_sel_i[0]),
    .i_idx(wb.wb_dat_i[IW-1:0]),
    .o_index(w_index),
    .o_data(data),
    .o_write_mem(write_mem),
    .o_busy(w_busy)
  );
  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = r_dat;
  assign {new_error, new_warning, new_report} = r_new;
  assign report_reg = r_report;
  assign warning_reg = r_warning;
  assign error_reg = r_error;
  assign index = w_index;
endmodule
